// File: rtl/key_scan_pkg.sv
// Shared types and constants for the keypad scanner: FSM state encoding,
// keymap lookup table and default timing values.
package key_scan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_SCAN_CYCLES     = 15;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 150000;

    // Indexed [row][col]; row3 follows the physical keypad legend, not hex order.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating terminal-count counter: counts enabled cycles from 0 up to
// TC_COUNT-1 and holds there until cleared.
module cycle_timer #(
    parameter  int unsigned TC_COUNT = 15,
    localparam int unsigned WIDTH    = (TC_COUNT > 1) ? $clog2(TC_COUNT) : 1
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o = (count_q == WIDTH'(TC_COUNT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/key_scan_fsm.sv
// 4x4 keypad scanner with press/release debounce and a one-cycle key_press pulse.
// Define GHOST_REJECT_EN to reject presses with more than one row low.
module key_scan_fsm
    import key_scan_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = DEFAULT_SCAN_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] R,
    output logic [3:0] C,
    output logic [3:0] key_code,
    output logic       key_press
);

    state_t     state_q, state_d;
    logic [1:0] col_q, col_d;
    logic [1:0] row_q, row_d;
    logic [3:0] code_q, code_d;
    logic       press_q, press_d;

    logic col_tc, col_clr, col_en;
    logic deb_tc, deb_clr, deb_en;
    logic any_low, all_high, row_stable;

    assign any_low  = ~&R;
    assign all_high = &R;

`ifdef GHOST_REJECT_EN
    assign row_stable = (R == ~(4'b0001 << row_q));
`else
    // Only the latched row matters; extra low rows are ignored.
    assign row_stable = ~R[row_q];
`endif

    assign col_en  = (state_q == ST_SCAN);
    assign col_clr = (state_q != ST_SCAN) || col_tc;
    assign deb_clr = (state_q == ST_SCAN) || (state_q == ST_HELD);
    assign deb_en  = ((state_q == ST_DEB_PRESS) && row_stable) ||
                     ((state_q == ST_DEB_RELEASE) && all_high);

    cycle_timer #(.TC_COUNT(SCAN_CYCLES)) u_col_timer (
        .clk     (clk),
        .rst_n_i (reset),
        .clr_i   (col_clr),
        .en_i    (col_en),
        .tc_o    (col_tc)
    );

    cycle_timer #(.TC_COUNT(DEBOUNCE_CYCLES)) u_deb_timer (
        .clk     (clk),
        .rst_n_i (reset),
        .clr_i   (deb_clr),
        .en_i    (deb_en),
        .tc_o    (deb_tc)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        code_d  = code_q;
        press_d = 1'b0;
        case (state_q)
            ST_SCAN: begin
                // A press wins over a column advance on the same cycle.
                if (any_low) begin
                    row_d   = lowest_low_row(R);
                    state_d = ST_DEB_PRESS;
                end else if (col_tc) begin
                    col_d = col_q + 2'd1;
                end
            end
            ST_DEB_PRESS: begin
                if (!row_stable) begin
                    state_d = ST_SCAN;
                end else if (deb_tc) begin
                    state_d = ST_HELD;
                    code_d  = KEYMAP[row_q][col_q];
                    press_d = 1'b1;
                end
            end
            ST_HELD: begin
                if (all_high) state_d = ST_DEB_RELEASE;
            end
            ST_DEB_RELEASE: begin
                if (!all_high) begin
                    state_d = ST_HELD;
                end else if (deb_tc) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            code_q  <= 4'h0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            code_q  <= code_d;
            press_q <= press_d;
        end
    end

    assign C         = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_press = press_q;

endmodule
